mc_main_controller: RTL and testbench
=====================================

Name: mc_main_controller

Overview:
- Multi-cycle RISC-V main control FSM, upstream of the immediate-extension stage: drives its 3-bit ImmSrc and all datapath enables/muxes from the latched instruction fields.
- One state per cycle. Supports lw, sw, R-ALU, I-ALU, beq/bne/blt/bge, jal, jalr, lui.

Parameters:
- STATE_W, 4, width of state register and debug state output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  Instr[6:0] from instruction register.
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- zero  in  1  ALU zero flag.
- neg  in  1  ALU result sign bit.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00=ALUOut, 01=MemData, 10=ALUResult.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4.
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=U, 100=J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Moore FSM. State register reset asynchronously to FETCH. Outputs decode from state, plus op/funct3/funct7b5 where noted.
- While rst_n=0: PCWrite, MemWrite, IRWrite, RegWrite and illegal are forced 0. All other outputs take FETCH values.
- Unlisted outputs in any state: 0 (ALUControl add, ImmSrc 000).
- FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, add, ResultSrc=10, PCWrite=1 -> DECODE.
- DECODE: SrcA=01, SrcB=01, add. ImmSrc=J if op=1101111, else B. Next state by op:
  - 0000011, 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - other -> FETCH with illegal=1 for this cycle.
- MEMADR: SrcA=10, SrcB=01, add. ImmSrc=S if op=0100011, else I. -> MEMWRITE (sw) / MEMREAD (lw).
- MEMREAD: AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH.
- EXECR: SrcA=10, SrcB=00, ALUControl from funct decode -> ALUWB.
- EXECI: SrcA=10, SrcB=01, ImmSrc=I, funct decode with funct7b5 ignored -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00. PCWrite = taken -> FETCH.
  - Taken: funct3 000 zero; 001 !zero; 100 neg; 101 !neg; any other funct3 never taken.
  - Overflow in blt/bge is not corrected.
- JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (writes OldPC+4).
- JALR: SrcA=10, SrcB=01, ImmSrc=I, add -> JALRPC.
- JALRPC: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
- LUI: SrcA=11, SrcB=01, ImmSrc=U, add -> ALUWB.
- Funct decode:
  - funct3 000: sub if R-type and funct7b5=1, else add.
  - 010 slt; 100 xor; 110 or; 111 and.
  - Unsupported funct3 -> add, not flagged illegal.
- Cycles per instruction, FETCH to next FETCH:
  - lw 5
  - sw, R, I, jal, lui 4
  - jalr 5
  - branch 3
  - illegal 2
- Reset asserted mid-instruction: immediate return to FETCH. No partial write enable may be seen after rst_n falls.

Test Plan:
- Release reset, op=0000011 -> states FETCH, DECODE, MEMADR(ImmSrc=000), MEMREAD(AdrSrc=1), MEMWB(RegWrite=1, ResultSrc=01), FETCH.
- op=0100011 -> MEMADR ImmSrc=001, then MEMWRITE MemWrite=1 for exactly one cycle, back to FETCH after 4 cycles total.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECR. Repeat with funct7b5=1 on op=0010011 -> ALUControl=000.
- op=1100011, funct3=001: zero=0 -> PCWrite=1 in BRANCH; zero=1 -> PCWrite=0. funct3=100 with neg=1 -> taken.
- op=1101111 -> DECODE ImmSrc=100, JAL PCWrite=1, ALUWB RegWrite=1. op=1100111 -> JALR ImmSrc=000, then JALRPC PCWrite=1.
- op=1111111 -> illegal=1 in DECODE, next state FETCH. Pull rst_n low during MEMWRITE -> MemWrite drops to 0 immediately, state=FETCH.

Source files
------------

// File: rtl/mc_main_controller.sv
// Multi-cycle RISC-V main control FSM: sequences fetch/decode/execute/writeback
// and decodes datapath enables, mux selects, ImmSrc and ALUControl from the state.
module mc_main_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               neg,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 0,
    S_DECODE   = 1,
    S_MEMADR   = 2,
    S_MEMREAD  = 3,
    S_MEMWB    = 4,
    S_MEMWRITE = 5,
    S_EXECR    = 6,
    S_EXECI    = 7,
    S_ALUWB    = 8,
    S_BRANCH   = 9,
    S_JAL      = 10,
    S_JALR     = 11,
    S_JALRPC   = 12,
    S_LUI      = 13
  } state_t;

  state_t cur;

  // Subtract only for R-type funct3=000 with funct7b5; unknown funct3 falls back to add.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_dec = sub ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b100:  alu_dec = 3'b100;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  logic taken;
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = neg;
      3'b101:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_R:         cur <= S_EXECR;
            OP_I:         cur <= S_EXECI;
            OP_BR:        cur <= S_BRANCH;
            OP_JAL:       cur <= S_JAL;
            OP_JALR:      cur <= S_JALR;
            OP_LUI:       cur <= S_LUI;
            default:      cur <= S_FETCH;
          endcase
        end
        S_MEMADR:   cur <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  cur <= S_MEMWB;
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_JALRPC,
        S_LUI:      cur <= S_ALUWB;
        S_JALR:     cur <= S_JALRPC;
        default:    cur <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = 3'b000;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b100 : 3'b010;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR: begin
        ALUSrcA = 2'b10; ALUControl = alu_dec(funct3, funct7b5);
      end
      S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_dec(funct3, 1'b0);
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUControl = 3'b001; PCWrite = taken;
      end
      S_JAL:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      S_JALR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_JALRPC: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      S_LUI:    begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = 3'b011; end
      default:  ;
    endcase
    // During reset the state is already FETCH; only the write strobes need masking.
    if (!rst_n) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_main_controller.sv
// Bench for mc_main_controller: per-instruction expected output sequences are
// queued by a reference model and compared cycle by cycle by a monitor.
module tb_mc_main_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] state;

  mc_main_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .state(state)
  );

  logic [17:0] got;
  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

  logic [17:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [17:0] actual, input logic [17:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s at %0t: got=%05h exp=%05h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [17:0] ov(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [2:0] alu,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic is_sub);
    if (f3 == 3'd0) return is_sub ? 3'd1 : 3'd0;
    if (f3 == 3'd2) return 3'd5;
    if (f3 == 3'd4) return 3'd4;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  // Reference model: the full per-cycle output trace of one instruction.
  task automatic model_push(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input logic n, output int cycles);
    logic [17:0] seq[$];
    logic [17:0] wb;
    logic legal;
    logic tk;
    wb = ov(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111) ||
            (o == 7'b1100111) || (o == 7'b0110111);
    seq.push_back(ov(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0));
    seq.push_back(ov(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1,
                     (o == 7'b1101111) ? 3'd4 : 3'd2, 3'd0, !legal));
    if (o == 7'b0000011) begin
      seq.push_back(ov(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0));
      seq.push_back(ov(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
      seq.push_back(ov(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    end else if (o == 7'b0100011) begin
      seq.push_back(ov(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0, 0));
      seq.push_back(ov(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    end else if (o == 7'b0110011) begin
      seq.push_back(ov(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, ref_alu(f3, f7), 0));
      seq.push_back(wb);
    end else if (o == 7'b0010011) begin
      seq.push_back(ov(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, ref_alu(f3, 1'b0), 0));
      seq.push_back(wb);
    end else if (o == 7'b1100011) begin
      tk = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && n) || (f3 == 3'd5 && !n);
      seq.push_back(ov(tk, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0));
    end else if (o == 7'b1101111) begin
      seq.push_back(ov(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0));
      seq.push_back(wb);
    end else if (o == 7'b1100111) begin
      seq.push_back(ov(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0));
      seq.push_back(ov(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0));
      seq.push_back(wb);
    end else if (o == 7'b0110111) begin
      seq.push_back(ov(0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 3'd3, 3'd0, 0));
      seq.push_back(wb);
    end
    cycles = seq.size();
    foreach (seq[i]) exp_q.push_back(seq[i]);
  endtask

  // driver: called just after a rising edge with the DUT in FETCH
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic n);
    int cycles;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
    model_push(o, f3, f7, z, n, cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [17:0] e;
      e = exp_q.pop_front();
      check("cycle_outputs", got, e);
    end
  end

  logic [17:0] rst_vec;
  logic [6:0] ops [8];
  int cyc;

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    rst_vec = ov(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0);
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", got, rst_vec);
    rst_n = 1'b1;

    run_instr(7'b0000011, 3'd2, 0, 0, 0);   // lw
    run_instr(7'b0100011, 3'd2, 0, 0, 0);   // sw
    run_instr(7'b0110011, 3'd0, 1, 0, 0);   // sub
    run_instr(7'b0010011, 3'd0, 1, 0, 0);   // addi, funct7b5 ignored
    run_instr(7'b0110011, 3'd7, 0, 0, 0);   // and
    run_instr(7'b1100011, 3'd1, 0, 0, 0);   // bne taken
    run_instr(7'b1100011, 3'd1, 0, 1, 0);   // bne not taken
    run_instr(7'b1100011, 3'd4, 0, 0, 1);   // blt taken
    run_instr(7'b1100011, 3'd2, 0, 1, 1);   // unsupported branch funct3
    run_instr(7'b1101111, 3'd0, 0, 0, 0);   // jal
    run_instr(7'b1100111, 3'd0, 0, 0, 0);   // jalr
    run_instr(7'b0110111, 3'd0, 0, 0, 0);   // lui
    run_instr(7'b1111111, 3'd0, 0, 0, 0);   // illegal

    // reset pulled during MEMWRITE of a store
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 0; zero = 0; neg = 0;
    model_push(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, cyc);
    repeat (cyc - 1) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_memwrite", got, rst_vec);
    @(posedge clk);
    #1;
    check("reset_hold", got, rst_vec);
    rst_n = 1'b1;
    run_instr(7'b0000011, 3'd2, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: leftover=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
